// File: rtl/sync_frame_capture.sv
// rtl/sync_frame_capture.sv - deserialises the payload and parity bit that follow a 1101 sync hit
// Frames land in a valid/ready output register with a parity flag, frame and drop counters.
module sync_frame_capture #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              sync_hit,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [DATA_W-1:0] frame_data,
  output logic              parity_err,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W:0]   sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              din_q;
  logic              sr_par;

  assign sr_par = ^sr;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      din_q       <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      parity_err  <= 1'b0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      // din_q lines the stream up with the registered sync_hit pulse
      din_q <= din;

      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sync_hit) begin
            sr      <= {sr[DATA_W-1:0], din_q};
            bit_cnt <= CNT_W'(1);
            state   <= CAPTURE;
          end
        end

        // sync_hit is ignored here since the payload itself may contain 1101
        CAPTURE: begin
          if (bit_cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            sr      <= {sr[DATA_W-1:0], din_q};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (!frame_valid || frame_ready) begin
            frame_valid <= 1'b1;
            frame_data  <= sr[DATA_W:1];
            parity_err  <= (sr_par != PAR_ODD);
            frame_cnt   <= frame_cnt + 16'd1;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
          bit_cnt <= '0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_capture.sv
// tb/tb_sync_frame_capture.sv - bench for sync_frame_capture, even and odd parity instances
// Directed scenarios plus random soak, checked every cycle against a frame-level model.
module tb_sync_frame_capture;

  localparam int NC = 16384;

  logic mclk;
  logic rst_n;
  logic din;
  logic sync_hit;
  logic frame_ready;

  logic        fv_e, fv_o;
  logic [7:0]  fd_e, fd_o;
  logic        pe_e, pe_o;
  logic [15:0] fc_e, fc_o;
  logic [7:0]  dc_e, dc_o;

  int checks = 0;
  int errors = 0;

  sync_frame_capture #(.DATA_W(8), .PARITY_ODD(0)) dut_e (
    .mclk(mclk), .rst_n(rst_n), .din(din), .sync_hit(sync_hit),
    .frame_ready(frame_ready), .frame_valid(fv_e), .frame_data(fd_e),
    .parity_err(pe_e), .frame_cnt(fc_e), .drop_cnt(dc_e)
  );

  sync_frame_capture #(.DATA_W(8), .PARITY_ODD(1)) dut_o (
    .mclk(mclk), .rst_n(rst_n), .din(din), .sync_hit(sync_hit),
    .frame_ready(frame_ready), .frame_valid(fv_o), .frame_data(fd_o),
    .parity_err(pe_o), .frame_cnt(fc_o), .drop_cnt(dc_o)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Model: din history plus the output slot and counters
  bit          din_log [NC];
  int          cyc;
  bit          m_valid;
  logic [7:0]  m_data;
  bit          m_perr_e, m_perr_o;
  logic [15:0] m_fcnt;
  logic [7:0]  m_dcnt;
  bit          m_pend;
  int          m_start;
  int          m_next_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_data = '0; m_perr_e = 0; m_perr_o = 0;
    m_fcnt = '0; m_dcnt = '0; m_pend = 0; m_start = 0; m_next_start = 0;
  endtask

  task automatic model_edge(input bit d, input bit s, input bit r);
    logic [7:0] fd;
    bit par, x, xfer, done;
    if (!rst_n) begin
      model_clear();
      din_log[cyc % NC] = 1'b0;
      cyc++;
      return;
    end
    din_log[cyc % NC] = d;
    xfer = m_valid && r;
    done = m_pend && (cyc == m_start + 10);
    if (done) begin
      fd = '0;
      for (int k = 0; k < 8; k++) fd = {fd[6:0], din_log[(m_start - 1 + k) % NC]};
      par = din_log[(m_start + 7) % NC];
      x = ^{fd, par};
      m_pend = 0;
      if (!m_valid || r) begin
        m_valid = 1; m_data = fd; m_perr_e = x; m_perr_o = !x;
        m_fcnt = m_fcnt + 16'd1;
      end else if (m_dcnt != 8'hFF) begin
        m_dcnt = m_dcnt + 8'd1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
    if (s && cyc >= m_next_start) begin
      m_pend = 1; m_start = cyc; m_next_start = cyc + 11;
    end
    cyc++;
  endtask

  task automatic compare_all();
    check("valid_e", {31'h0, fv_e}, {31'h0, m_valid});
    check("valid_o", {31'h0, fv_o}, {31'h0, m_valid});
    check("data_e", {24'h0, fd_e}, {24'h0, m_data});
    check("data_o", {24'h0, fd_o}, {24'h0, m_data});
    check("perr_e", {31'h0, pe_e}, {31'h0, m_perr_e});
    check("perr_o", {31'h0, pe_o}, {31'h0, m_perr_o});
    check("fcnt_e", {16'h0, fc_e}, {16'h0, m_fcnt});
    check("fcnt_o", {16'h0, fc_o}, {16'h0, m_fcnt});
    check("dcnt_e", {24'h0, dc_e}, {24'h0, m_dcnt});
    check("dcnt_o", {24'h0, dc_o}, {24'h0, m_dcnt});
  endtask

  task automatic tick(input bit d, input bit s, input bit r);
    din = d; sync_hit = s; frame_ready = r;
    @(posedge mclk);
    model_edge(d, s, r);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)), 1'b0, r);
  endtask

  // Bit 0 is driven one cycle ahead of sync_hit so din_q carries it on the hit edge.
  task automatic send_frame(input logic [7:0] d, input bit p, input bit r, input bit mid);
    logic [8:0] bits;
    bits = {d, p};
    tick(bits[8], 1'b0, r);
    tick(bits[7], 1'b1, r);
    for (int k = 2; k < 9; k++) tick(bits[8 - k], mid && (k == 4), r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", {31'h0, fv_e | fv_o}, 32'h0);
    check("rst_data", {16'h0, fd_e, fd_o}, 32'h0);
    check("rst_perr", {30'h0, pe_e, pe_o}, 32'h0);
    check("rst_fcnt", {fc_e, fc_o}, 32'h0);
    check("rst_dcnt", {16'h0, dc_e, dc_o}, 32'h0);
    idle(3, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b0);
  endtask

  initial begin
    cyc = 0;
    model_clear();
    din = 0; sync_hit = 0; frame_ready = 0; rst_n = 1'b0;
    #1;
    do_reset();

    // 1: 0xA5 with even parity bit, consumer always ready
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("t1_not_yet", {31'h0, fv_e}, 32'h0);
    idle(1, 1'b1);
    check("t1_valid", {31'h0, fv_e}, 32'h1);
    check("t1_data", {24'h0, fd_e}, 32'hA5);
    check("t1_perr_even", {31'h0, pe_e}, 32'h0);
    check("t1_fcnt", {16'h0, fc_e}, 32'h1);
    idle(1, 1'b1);
    check("t1_one_cycle", {31'h0, fv_e}, 32'h0);

    // 2: parity bit 1 -> even errors, odd passes
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("t2_data", {24'h0, fd_e}, 32'hA5);
    check("t2_perr_even", {31'h0, pe_e}, 32'h1);
    check("t2_perr_odd", {31'h0, pe_o}, 32'h0);
    check("t2_fcnt", {16'h0, fc_e}, 32'h2);
    idle(2, 1'b1);

    // 3: backpressure holds 0x3C, 0xC3 dropped
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("t3_data_first", {24'h0, fd_e}, 32'h3C);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("t3_data_held", {24'h0, fd_e}, 32'h3C);
    check("t3_valid_held", {31'h0, fv_e}, 32'h1);
    check("t3_dcnt", {24'h0, dc_e}, 32'h1);
    check("t3_fcnt", {16'h0, fc_e}, 32'h1);
    idle(1, 1'b1);
    check("t3_xfer", {31'h0, fv_e}, 32'h0);

    // 4: ready arrives exactly on the DONE edge of 0x81
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("t4_before", {24'h0, fd_e}, 32'h3C);
    idle(1, 1'b1);
    check("t4_valid", {31'h0, fv_e}, 32'h1);
    check("t4_data", {24'h0, fd_e}, 32'h81);
    check("t4_dcnt", {24'h0, dc_e}, 32'h0);
    check("t4_fcnt", {16'h0, fc_e}, 32'h2);
    idle(2, 1'b1);

    // 5: payload 0x0D with a sync pulse mid-capture
    send_frame(8'h0D, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("t5_data", {24'h0, fd_e}, 32'h0D);
    check("t5_fcnt", {16'h0, fc_e}, 32'h3);
    idle(15, 1'b1);
    check("t5_no_restart", {16'h0, fc_e}, 32'h3);

    // 6: async reset after 4 captured bits, then 0x5A and a drop flood
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("t6_data", {24'h0, fd_e}, 32'h5A);
    check("t6_fcnt", {16'h0, fc_e}, 32'h1);
    for (int i = 0; i < 301; i++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    check("t6_dcnt_sat", {24'h0, dc_e}, 32'hFF);
    check("t6_fcnt_after", {16'h0, fc_e}, 32'h1);
    idle(3, 1'b1);

    // Random soak: raw din and sync_hit streams, random backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
